// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the 8-bit CPU control sequencer: opcodes, one-hot
// T-states and control-word bit positions.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_JC  = 4'b0100;
    localparam logic [3:0] OP_JZ  = 4'b0101;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int TS_W = 6;

    typedef enum logic [TS_W-1:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    localparam int CW_PC_INC   = 0;
    localparam int CW_PC_OUT   = 1;
    localparam int CW_PC_LOAD  = 2;
    localparam int CW_MAR_LOAD = 3;
    localparam int CW_RAM_OUT  = 4;
    localparam int CW_IR_LOAD  = 5;
    localparam int CW_IR_OUT   = 6;
    localparam int CW_A_LOAD   = 7;
    localparam int CW_A_OUT    = 8;
    localparam int CW_B_LOAD   = 9;
    localparam int CW_OUT_LOAD = 10;
    localparam int CW_ALU_OUT  = 11;
    localparam int CW_ALU_CUT  = 12;
    localparam int CW_W        = 13;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/cpu_ctrl_seq_ring.sv
// ctrl_ring_counter: six-state one-hot T-state ring with synchronous reset,
// run enable and a freeze input that pins the current state (used for halt).
module ctrl_ring_counter
    import cpu_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            freeze,
    output logic [TS_W-1:0] tstate
);

    always_ff @(posedge clk) begin
        if (rst)
            tstate <= T1;
        else if (en && !freeze)
            tstate <= {tstate[TS_W-2:0], tstate[TS_W-1]};
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Control sequencer for the 8-bit CPU: T-state ring plus opcode decoder.
// Define CTRL_JMP_EN to add JMP/JC/JZ and the carry/zero flag register.
module cpu_ctrl_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] ctrl_op,
    input  logic            ctrl_run,
    input  logic            alu_cy,
    input  logic            alu_z,
    output logic            ctrl_pc_inc,
    output logic            ctrl_pc_out,
    output logic            ctrl_pc_load,
    output logic            ctrl_mar_load,
    output logic            ctrl_ram_out,
    output logic            ctrl_ir_load,
    output logic            ctrl_ir_out,
    output logic            ctrl_a_load,
    output logic            ctrl_a_out,
    output logic            ctrl_b_load,
    output logic            ctrl_out_load,
    output logic            alu_out,
    output logic            alu_cut,
    output logic            ctrl_halt,
    output logic [5:0]      ctrl_tstate,
    output logic            ctrl_flag_cy,
    output logic            ctrl_flag_z
);

    logic [TS_W-1:0] tstate;
    logic            halt_q;
    logic            active;
    logic            hlt_now;
    ctrl_word_t      cw;

    logic is_lda, is_add, is_sub, is_out, is_hlt;
    assign is_lda = (ctrl_op == OP_W'(OP_LDA));
    assign is_add = (ctrl_op == OP_W'(OP_ADD));
    assign is_sub = (ctrl_op == OP_W'(OP_SUB));
    assign is_out = (ctrl_op == OP_W'(OP_OUT));
    assign is_hlt = (ctrl_op == OP_W'(OP_HLT));

    // Controls are only live when running, out of reset and not halted.
    assign active  = !rst && ctrl_run && !halt_q;
    assign hlt_now = active && (tstate == T4) && is_hlt;

    ctrl_ring_counter u_ring (
        .clk    (clk),
        .rst    (rst),
        .en     (ctrl_run),
        .freeze (halt_q | hlt_now),
        .tstate (tstate)
    );

    always_ff @(posedge clk) begin
        if (rst)
            halt_q <= 1'b0;
        else if (hlt_now)
            halt_q <= 1'b1;
    end

`ifdef CTRL_JMP_EN
    logic flag_cy, flag_z;
    logic is_jmp, is_jc, is_jz, jmp_take;
    assign is_jmp   = (ctrl_op == OP_W'(OP_JMP));
    assign is_jc    = (ctrl_op == OP_W'(OP_JC));
    assign is_jz    = (ctrl_op == OP_W'(OP_JZ));
    assign jmp_take = is_jmp || (is_jc && flag_cy) || (is_jz && flag_z);

    // Flags update on the advancing edge out of ADD/SUB T6 only.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_cy <= 1'b0;
            flag_z  <= 1'b0;
        end else if (active && (tstate == T6) && (is_add || is_sub)) begin
            flag_cy <= alu_cy;
            flag_z  <= alu_z;
        end
    end
`else
    logic flag_cy, flag_z;
    logic unused_alu_flags;
    assign flag_cy          = 1'b0;
    assign flag_z           = 1'b0;
    assign unused_alu_flags = alu_cy ^ alu_z;
`endif

    always_comb begin
        cw = '0;
        case (tstate)
            T1: begin
                cw[CW_PC_OUT]   = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
            end
            T2: cw[CW_PC_INC] = 1'b1;
            T3: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_LOAD] = 1'b1;
            end
            T4: begin
                if (is_lda || is_add || is_sub) begin
                    cw[CW_IR_OUT]   = 1'b1;
                    cw[CW_MAR_LOAD] = 1'b1;
                end else if (is_out) begin
                    cw[CW_A_OUT]    = 1'b1;
                    cw[CW_OUT_LOAD] = 1'b1;
                end
`ifdef CTRL_JMP_EN
                else if (jmp_take) begin
                    cw[CW_IR_OUT]  = 1'b1;
                    cw[CW_PC_LOAD] = 1'b1;
                end
`endif
            end
            T5: begin
                if (is_lda) begin
                    cw[CW_RAM_OUT] = 1'b1;
                    cw[CW_A_LOAD]  = 1'b1;
                end else if (is_add || is_sub) begin
                    cw[CW_RAM_OUT] = 1'b1;
                    cw[CW_B_LOAD]  = 1'b1;
                end
            end
            T6: begin
                if (is_add || is_sub) begin
                    cw[CW_ALU_OUT] = 1'b1;
                    cw[CW_A_LOAD]  = 1'b1;
                    cw[CW_ALU_CUT] = is_sub;
                end
            end
            default: cw = '0;
        endcase
        if (!active)
            cw = '0;
    end

    assign ctrl_pc_inc   = cw[CW_PC_INC];
    assign ctrl_pc_out   = cw[CW_PC_OUT];
    assign ctrl_pc_load  = cw[CW_PC_LOAD];
    assign ctrl_mar_load = cw[CW_MAR_LOAD];
    assign ctrl_ram_out  = cw[CW_RAM_OUT];
    assign ctrl_ir_load  = cw[CW_IR_LOAD];
    assign ctrl_ir_out   = cw[CW_IR_OUT];
    assign ctrl_a_load   = cw[CW_A_LOAD];
    assign ctrl_a_out    = cw[CW_A_OUT];
    assign ctrl_b_load   = cw[CW_B_LOAD];
    assign ctrl_out_load = cw[CW_OUT_LOAD];
    assign alu_out       = cw[CW_ALU_OUT];
    assign alu_cut       = cw[CW_ALU_CUT];

    assign ctrl_halt    = halt_q;
    assign ctrl_tstate  = tstate;
    assign ctrl_flag_cy = flag_cy;
    assign ctrl_flag_z  = flag_z;

endmodule
